// File: rtl/uart_rx_pkg.sv
// ============================================================================
// uart_rx_pkg : board timing constants and FSM encodings shared by the UART
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_rx_pkg;

    localparam int CLK_FREQ_HZ     = 100_000_000;
    localparam int BAUD_RATE       = 9600;
    localparam int OVS_RATE        = 16;
    localparam int OVS_DIV_DEFAULT = CLK_FREQ_HZ / (OVS_RATE * BAUD_RATE);

    // Encodings are shared with the transmitter FSM, so values are pinned.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } uart_state_t;

    function automatic logic state_is_busy(input uart_state_t s);
        return (s == S_START) || (s == S_DATA) || (s == S_STOP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// ============================================================================
// baud_tick_gen : free-running divider producing a one-clock tick every MAX
// clocks; 'clear' holds the phase at zero. Rev 1.0
// ============================================================================
`default_nettype none

module baud_tick_gen #(
    parameter int MAX = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (MAX > 1) ? $clog2(MAX) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == CW'(MAX - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(MAX - 1));

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 UART receiver with 16x oversampling and frame-error detection
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int OVS_DIV = OVS_DIV_DEFAULT,
    parameter int NBITS   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RxD,
    output logic [NBITS-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_busy,
    output logic             rx_frame_err
);

    localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    uart_state_t      state, state_next;
    logic             rxd_meta, rxd_s;
    logic             tick, tick_clear;
    logic [3:0]       ovs_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [NBITS-1:0] shift;
    logic             ovs_clr, bit_clr, sample, frame_good, frame_bad;

    // Synchronizer resets high so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= RxD;
            rxd_s    <= rxd_meta;
        end
    end

    assign tick_clear = (state == S_IDLE) || (state == S_WAIT_HIGH);

    baud_tick_gen #(
        .MAX (OVS_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ovs_clr    = 1'b0;
        bit_clr    = 1'b0;
        sample     = 1'b0;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_next = S_START;
                    ovs_clr    = 1'b1;
                end
            end
            S_START: begin
                if (tick && ovs_cnt == 4'd7) begin
                    if (!rxd_s) begin
                        state_next = S_DATA;
                        ovs_clr    = 1'b1;
                        bit_clr    = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick && ovs_cnt == 4'd15) begin
                    sample = 1'b1;
                    if (bit_cnt == BIT_W'(NBITS - 1)) begin
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick && ovs_cnt == 4'd15) begin
                    if (rxd_s) begin
                        frame_good = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rxd_s) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_busy = state_is_busy(state);
    end

    // LSB arrives first, so bits enter at the top and walk down.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovs_cnt      <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= frame_good;
            rx_frame_err <= frame_bad;
            if (ovs_clr) begin
                ovs_cnt <= '0;
            end else if (tick) begin
                ovs_cnt <= ovs_cnt + 4'd1;
            end
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (sample) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (sample) begin
                shift <= {rxd_s, shift[NBITS-1:1]};
            end
            if (frame_good) begin
                rx_data <= shift;
            end
        end
    end

endmodule

`default_nettype wire
